muldiv_unit: RTL and testbench

Iterative 32-cycle multiply/divide responder for the MIPS pipeline's HI/LO path. The control unit issues mult/multu/div/divu from the EXE stage with a one-cycle `start` pulse. This block computes the 64-bit product or the quotient/remainder one bit per cycle. It returns `hi`/`lo` with a `done` pulse, and holds `busy` so the hazard logic can stall mfhi/mflo/mthi/mtlo and any new mul/div.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_if.sv | 25 ++
 rtl/muldiv_signfix.sv | 24 ++
 rtl/muldiv_unit.sv | 159 +++++++++++++++
 tb/tb_muldiv_unit.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

   localparam int MD_WIDTH = 32;

   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_FIN  = 2'd2
   } md_state_e;

   // op[1] selects divide, op[0] selects the unsigned variant
   function automatic logic md_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic md_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the EXE-stage control and the mul/div unit.
interface muldiv_if #(
   parameter int WIDTH = muldiv_pkg::MD_WIDTH
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cancel;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_by_zero;

   modport master (
      output start, op, a, b, cancel,
      input  busy, done, hi, lo, div_by_zero
   );

   modport slave (
      input  start, op, a, b, cancel,
      output busy, done, hi, lo, div_by_zero
   );
endinterface

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate on a 2*HW-bit word, either as one value
// or as two independent HW-bit halves (operand pair, quotient/remainder pair).
module muldiv_signfix #(
   parameter int HW = 32
) (
   input  logic [2*HW-1:0] val,
   input  logic            split,
   input  logic            neg_hi,
   input  logic            neg_lo,
   output logic [2*HW-1:0] res
);

   // whole-word negate uses neg_lo; split mode negates each half on its own flag
   always_comb begin
      res = val;
      if (split) begin
         if (neg_hi) res[2*HW-1:HW] = -val[2*HW-1:HW];
         if (neg_lo) res[HW-1:0]    = -val[HW-1:0];
      end else if (neg_lo) begin
         res = -val;
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide for the HI/LO path.
//
// state | meaning
// IDLE  | waiting for start; hi/lo hold last result
// RUN   | one shift-add or shift-subtract iteration per cycle (busy=1)
// FIN   | result registered on entry; done pulse; start here chains next op
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic     clk,
   input  logic     rst,
   muldiv_if.slave  md
);

   localparam logic [1:0] ST_IDLE = MD_IDLE;
   localparam logic [1:0] ST_RUN  = MD_RUN;
   localparam logic [1:0] ST_FIN  = MD_FIN;

   localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);
   localparam logic [5:0] CNT_SAT  = 6'(WIDTH);

   logic [1:0]         state, state_nxt;
   logic [5:0]         cnt;
   logic               is_div_r;
   logic               sign_q, sign_r;
   logic               dbz_pend;
   logic [WIDTH-1:0]   opnd_r;
   logic [2*WIDTH:0]   acc, acc_nxt;
   logic [WIDTH-1:0]   hi_r, lo_r;
   logic               dbz_r;

   logic               accept;
   logic               last_iter;
   logic               op_signed;
   logic [2*WIDTH-1:0] abs_ab;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [2*WIDTH-1:0] res_fix;
   logic               fix_lo;

   logic [WIDTH:0]     mul_upper;
   logic [WIDTH+1:0]   div_rem_sh;
   logic [WIDTH+1:0]   div_diff;

   assign op_signed = md_is_signed(md.op);
   assign accept    = (state != ST_RUN) && md.start && !md.cancel;
   assign last_iter = (state == ST_RUN) && (cnt == CNT_LAST);

   muldiv_signfix #(.HW(WIDTH)) u_abs (
      .val    ({md.a, md.b}),
      .split  (1'b1),
      .neg_hi (op_signed & md.a[WIDTH-1]),
      .neg_lo (op_signed & md.b[WIDTH-1]),
      .res    (abs_ab)
   );

   assign abs_a = abs_ab[2*WIDTH-1:WIDTH];
   assign abs_b = abs_ab[WIDTH-1:0];

   // divide by zero keeps the raw all-ones quotient; hi fix-up by the dividend
   // sign turns |a| back into a
   assign fix_lo = sign_q & ~dbz_pend;

   muldiv_signfix #(.HW(WIDTH)) u_fix (
      .val    (acc_nxt[2*WIDTH-1:0]),
      .split  (is_div_r),
      .neg_hi (sign_r),
      .neg_lo (fix_lo),
      .res    (res_fix)
   );

   // one datapath iteration: shift-add for multiply, shift-subtract for divide
   always_comb begin
      acc_nxt    = acc;
      mul_upper  = '0;
      div_rem_sh = '0;
      div_diff   = '0;
      if (is_div_r) begin
         div_rem_sh = {acc[2*WIDTH:WIDTH], acc[WIDTH-1]};
         div_diff   = div_rem_sh - {2'b00, opnd_r};
         if (!div_diff[WIDTH+1]) begin
            acc_nxt = {div_diff[WIDTH:0], acc[WIDTH-2:0], 1'b1};
         end else begin
            acc_nxt = {div_rem_sh[WIDTH:0], acc[WIDTH-2:0], 1'b0};
         end
      end else begin
         mul_upper = {1'b0, acc[2*WIDTH-1:WIDTH]}
                   + (acc[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
         acc_nxt   = {1'b0, mul_upper, acc[WIDTH-1:1]};
      end
   end

   // next-state decode; cancel wins over both start and completion
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = ST_RUN;
         ST_RUN: begin
            if (md.cancel)     state_nxt = ST_IDLE;
            else if (last_iter) state_nxt = ST_FIN;
         end
         ST_FIN:  state_nxt = accept ? ST_RUN : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // operand latch on accept, then iterate until the counter saturates
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         is_div_r <= 1'b0;
         sign_q   <= 1'b0;
         sign_r   <= 1'b0;
         dbz_pend <= 1'b0;
         opnd_r   <= '0;
         acc      <= '0;
      end else if (accept) begin
         cnt      <= '0;
         is_div_r <= md_is_div(md.op);
         sign_q   <= op_signed & (md.a[WIDTH-1] ^ md.b[WIDTH-1]);
         sign_r   <= op_signed & md.a[WIDTH-1];
         dbz_pend <= md_is_div(md.op) && (md.b == '0);
         opnd_r   <= md_is_div(md.op) ? abs_b : abs_a;
         acc      <= {1'b0, {WIDTH{1'b0}}, (md_is_div(md.op) ? abs_a : abs_b)};
      end else if ((state == ST_RUN) && !md.cancel) begin
         acc <= acc_nxt;
         if (cnt != CNT_SAT) cnt <= cnt + 6'd1;
      end
   end

   // architectural results: written only on FIN entry, flag cleared by a new op
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_r  <= '0;
         lo_r  <= '0;
         dbz_r <= 1'b0;
      end else if (accept) begin
         dbz_r <= 1'b0;
      end else if (last_iter && !md.cancel) begin
         hi_r  <= res_fix[2*WIDTH-1:WIDTH];
         lo_r  <= dbz_pend ? {WIDTH{1'b1}} : res_fix[WIDTH-1:0];
         dbz_r <= dbz_pend;
      end
   end

   assign md.busy        = (state == ST_RUN);
   assign md.done        = (state == ST_FIN) && !md.cancel;
   assign md.hi          = hi_r;
   assign md.lo          = lo_r;
   assign md.div_by_zero = dbz_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results, divide-by-zero, ignored
// start, back-to-back issue, cancel and mid-operation reset.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] prev_hi = '0;
   logic [31:0] prev_lo = '0;

   muldiv_if #(.WIDTH(32)) md ();

   muldiv_unit #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .md  (md)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // drive start in the current cycle (cycle 0); returns at cycle 1
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      md.op    = op;
      md.a     = a;
      md.b     = b;
      md.start = 1'b1;
      @(negedge clk);
      md.start = 1'b0;
   endtask

   // cycles first..last of a running op: busy high, no done, hi/lo unchanged
   task automatic wait_run(input string tag, input int first, input int last,
                           input logic [31:0] hold_hi, input logic [31:0] hold_lo);
      for (int c = first; c <= last; c++) begin
         chk($sformatf("%s busy/done c%0d", tag, c), {62'd0, md.busy, md.done}, 64'd2);
         chk($sformatf("%s hold c%0d", tag, c), {md.hi, md.lo}, {hold_hi, hold_lo});
         @(negedge clk);
      end
   endtask

   task automatic check_done(input string tag, input logic [31:0] ehi,
                             input logic [31:0] elo, input logic edbz);
      chk({tag, " done"}, {62'd0, md.busy, md.done}, 64'd1);
      chk({tag, " hi"}, {32'd0, md.hi}, {32'd0, ehi});
      chk({tag, " lo"}, {32'd0, md.lo}, {32'd0, elo});
      chk({tag, " dbz"}, {63'd0, md.div_by_zero}, {63'd0, edbz});
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi,
                         input logic [31:0] elo, input logic edbz);
      issue(op, a, b);
      wait_run(tag, 1, 32, prev_hi, prev_lo);
      check_done(tag, ehi, elo, edbz);
      prev_hi = ehi;
      prev_lo = elo;
      @(negedge clk);
      chk({tag, " idle after"}, {62'd0, md.busy, md.done}, 64'd0);
   endtask

   initial begin
      md.start  = 1'b0;
      md.cancel = 1'b0;
      md.op     = MD_MULT;
      md.a      = '0;
      md.b      = '0;

      repeat (3) @(negedge clk);
      chk("reset busy/done", {62'd0, md.busy, md.done}, 64'd0);
      chk("reset hi/lo", {md.hi, md.lo}, 64'd0);
      chk("reset dbz", {63'd0, md.div_by_zero}, 64'd0);
      rst = 1'b0;

      run_op("mult -1*2", MD_MULT, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
      run_op("multu max*max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0);
      run_op("mult -3*5", MD_MULT, 32'hFFFF_FFFD, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
      run_op("mult min*min", MD_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
      run_op("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      run_op("divu 7/2", MD_DIVU, 32'h7, 32'h2, 32'h1, 32'h3, 1'b0);
      run_op("div min/-1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
      run_op("div 7/-2", MD_DIV, 32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 1'b0);
      run_op("divu 5/0", MD_DIVU, 32'h5, 32'h0, 32'h5, 32'hFFFF_FFFF, 1'b1);
      repeat (3) @(negedge clk);
      chk("dbz held in idle", {63'd0, md.div_by_zero}, 64'd1);
      run_op("div -5/0", MD_DIV, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);

      issue(MD_DIVU, 32'h7, 32'h2);
      chk("dbz cleared by start", {63'd0, md.div_by_zero}, 64'd0);
      wait_run("divu after dbz", 1, 32, prev_hi, prev_lo);
      check_done("divu after dbz", 32'h1, 32'h3, 1'b0);
      prev_hi = 32'h1;
      prev_lo = 32'h3;
      @(negedge clk);

      // start pulsed while busy is ignored; start in the done cycle chains
      issue(MD_DIV, 32'd100, 32'd7);
      wait_run("ign", 1, 9, prev_hi, prev_lo);
      md.op    = MD_MULT;
      md.a     = 32'd3;
      md.b     = 32'd3;
      md.start = 1'b1;
      wait_run("ign", 10, 10, prev_hi, prev_lo);
      md.start = 1'b0;
      wait_run("ign", 11, 32, prev_hi, prev_lo);
      check_done("ign div 100/7", 32'd2, 32'd14, 1'b0);
      prev_hi = 32'd2;
      prev_lo = 32'd14;
      issue(MD_DIVU, 32'd1000, 32'd10);
      wait_run("b2b", 1, 32, prev_hi, prev_lo);
      check_done("b2b divu 1000/10", 32'd0, 32'd100, 1'b0);
      prev_hi = 32'd0;
      prev_lo = 32'd100;
      @(negedge clk);
      chk("b2b idle after", {62'd0, md.busy, md.done}, 64'd0);

      // cancel mid-run: idle next cycle, no done, results untouched
      issue(MD_MULTU, 32'd5, 32'd6);
      wait_run("cancel", 1, 9, prev_hi, prev_lo);
      md.cancel = 1'b1;
      wait_run("cancel", 10, 10, prev_hi, prev_lo);
      md.cancel = 1'b0;
      for (int c = 11; c <= 40; c++) begin
         chk($sformatf("cancel idle c%0d", c), {62'd0, md.busy, md.done}, 64'd0);
         chk($sformatf("cancel hold c%0d", c), {md.hi, md.lo}, {prev_hi, prev_lo});
         @(negedge clk);
      end

      md.op     = MD_MULT;
      md.a      = 32'd2;
      md.b      = 32'd2;
      md.start  = 1'b1;
      md.cancel = 1'b1;
      @(negedge clk);
      md.start  = 1'b0;
      md.cancel = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         chk($sformatf("start+cancel idle c%0d", c), {62'd0, md.busy, md.done}, 64'd0);
         @(negedge clk);
      end

      run_op("multu 5*6", MD_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);

      // reset mid-run clears everything
      run_op("divu 9/0", MD_DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 1'b1);
      issue(MD_MULT, 32'd3, 32'd4);
      wait_run("rst", 1, 9, prev_hi, prev_lo);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst busy/done", {62'd0, md.busy, md.done}, 64'd0);
      chk("rst hi/lo", {md.hi, md.lo}, 64'd0);
      chk("rst dbz", {63'd0, md.div_by_zero}, 64'd0);
      prev_hi = '0;
      prev_lo = '0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         chk($sformatf("rst idle c%0d", c), {62'd0, md.busy, md.done}, 64'd0);
      end
      run_op("mult 7*9 after rst", MD_MULT, 32'd7, 32'd9, 32'd0, 32'd63, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
